// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Covers the controller FSM states and the EX operand forward-select codes.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      TRAP     = 2'd2
   } state_t;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   // EX/MEM result is younger than MEM/WB, so it takes priority.
   function automatic logic [1:0] fwd_select(input logic hit_exmem, input logic hit_memwb);
      if (hit_exmem)      return FWD_EXMEM;
      else if (hit_memwb) return FWD_MEMWB;
      else                return FWD_RF;
   endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// Combinational EX-stage operand forwarding selects.
// Register 0 is hard-wired zero and is never forwarded.
module pipe_fwd_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned REG_AW = 5
) (
   input  logic [REG_AW-1:0] i_ex_rs,
   input  logic [REG_AW-1:0] i_ex_rt,
   input  logic [REG_AW-1:0] i_mem_rd,
   input  logic              i_mem_reg_write,
   input  logic [REG_AW-1:0] i_wb_rd,
   input  logic              i_wb_reg_write,
   output logic [1:0]        o_fwd_a,
   output logic [1:0]        o_fwd_b
);

   logic w_mem_valid;
   logic w_wb_valid;

   always_comb begin
      w_mem_valid = i_mem_reg_write && (i_mem_rd != '0);
      w_wb_valid  = i_wb_reg_write  && (i_wb_rd  != '0);
      o_fwd_a     = fwd_select(w_mem_valid && (i_mem_rd == i_ex_rs),
                               w_wb_valid  && (i_wb_rd  == i_ex_rs));
      o_fwd_b     = fwd_select(w_mem_valid && (i_mem_rd == i_ex_rt),
                               w_wb_valid  && (i_wb_rd  == i_ex_rt));
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the five-stage pipeline.
// Stage controls are combinational so stalls act in the same cycle.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned REG_AW      = 5,
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rt,
   input  logic              id_branch_taken,
   input  logic [REG_AW-1:0] ex_rs,
   input  logic [REG_AW-1:0] ex_rt,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   input  logic              ex_reg_write,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_reg_write,
   input  logic              mem_access,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_reg_write,
   input  logic              dmem_ready,
   output logic              pc_en,
   output logic              ifid_en,
   output logic              idex_en,
   output logic              exmem_en,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic              memwb_flush,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              dmem_req,
   output logic              timeout_err,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  flush_count
);

   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [WAIT_W-1:0]   r_wait_cnt;
   logic [WAIT_W-1:0]   w_wait_nxt;
   logic                r_timeout_err;
   logic [CNT_W-1:0]    r_stall_cycles;
   logic [CNT_W-1:0]    r_flush_count;
   logic                w_load_use;
   logic                w_flush_evt;
   logic                w_stall_evt;
   logic [1:0]          w_fwd_a;
   logic [1:0]          w_fwd_b;

   pipe_fwd_unit #(.REG_AW(REG_AW)) u_fwd (
      .i_ex_rs         (ex_rs),
      .i_ex_rt         (ex_rt),
      .i_mem_rd        (mem_rd),
      .i_mem_reg_write (mem_reg_write),
      .i_wb_rd         (wb_rd),
      .i_wb_reg_write  (wb_reg_write),
      .o_fwd_a         (w_fwd_a),
      .o_fwd_b         (w_fwd_b)
   );

   always_comb begin
      w_load_use = ex_mem_read && ex_reg_write && (ex_rd != '0) &&
                   ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      exmem_en    = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      memwb_flush = 1'b0;
      dmem_req    = mem_access;
      fwd_a       = w_fwd_a;
      fwd_b       = w_fwd_b;
      w_state_nxt = r_state;
      w_wait_nxt  = r_wait_cnt;
      w_flush_evt = 1'b0;

      if (reset) begin
         {pc_en, ifid_en, idex_en, exmem_en} = '0;
         {ifid_flush, idex_flush, memwb_flush} = '1;
         dmem_req = 1'b0;
         fwd_a    = FWD_RF;
         fwd_b    = FWD_RF;
      end else begin
         unique case (r_state)
            RUN: begin
               if (mem_access && !dmem_ready) begin
                  {pc_en, ifid_en, idex_en, exmem_en} = '0;
                  memwb_flush = 1'b1;
                  dmem_req    = 1'b1;
                  w_wait_nxt  = WAIT_W'(1);
                  // The RUN cycle already counts as the first wait cycle.
                  w_state_nxt = (MEM_TIMEOUT <= 1) ? TRAP : MEM_WAIT;
               end else if (w_load_use) begin
                  pc_en      = 1'b0;
                  ifid_en    = 1'b0;
                  idex_flush = 1'b1;
               end else if (id_branch_taken) begin
                  ifid_flush  = 1'b1;
                  w_flush_evt = 1'b1;
               end
            end
            MEM_WAIT: begin
               dmem_req = 1'b1;
               if (dmem_ready) begin
                  w_state_nxt = RUN;
                  w_wait_nxt  = '0;
               end else begin
                  {pc_en, ifid_en, idex_en, exmem_en} = '0;
                  memwb_flush = 1'b1;
                  w_wait_nxt  = r_wait_cnt + WAIT_W'(1);
                  if (w_wait_nxt == WAIT_W'(MEM_TIMEOUT)) w_state_nxt = TRAP;
               end
            end
            TRAP: begin
               {pc_en, ifid_en, idex_en, exmem_en} = '0;
               {ifid_flush, idex_flush, memwb_flush} = '1;
               dmem_req = 1'b0;
            end
            default: w_state_nxt = RUN;
         endcase
      end

      w_stall_evt = !reset && !pc_en && (r_state != TRAP);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= RUN;
         r_wait_cnt     <= '0;
         r_timeout_err  <= 1'b0;
         r_stall_cycles <= '0;
         r_flush_count  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
         if (w_state_nxt == TRAP) r_timeout_err <= 1'b1;
         if (w_stall_evt && (r_stall_cycles != '1))
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
         if (w_flush_evt && (r_flush_count != '1))
            r_flush_count <= r_flush_count + CNT_W'(1);
      end
   end

   assign timeout_err  = r_timeout_err;
   assign stall_cycles = r_stall_cycles;
   assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scenarios plus randomized run against a behavioural reference model.
module tb_pipeline_hazard_ctrl;

   localparam int REG_AW  = 5;
   localparam int TIMEOUT = 15;
   localparam int CNT_W   = 4;
   localparam int SAT     = 15;

   logic              clk = 1'b0;
   logic              reset;
   logic [REG_AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
   logic              id_uses_rt, id_branch_taken, ex_mem_read, ex_reg_write;
   logic              mem_reg_write, mem_access, wb_reg_write, dmem_ready;
   logic              pc_en, ifid_en, idex_en, exmem_en;
   logic              ifid_flush, idex_flush, memwb_flush;
   logic [1:0]        fwd_a, fwd_b;
   logic              dmem_req, timeout_err;
   logic [CNT_W-1:0]  stall_cycles, flush_count;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.REG_AW(REG_AW), .MEM_TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_branch_taken(id_branch_taken),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
      .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_access(mem_access),
      .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .dmem_ready(dmem_ready),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .dmem_req(dmem_req), .timeout_err(timeout_err),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   task automatic idle();
      id_rs = '0; id_rt = '0; id_uses_rt = 0; id_branch_taken = 0;
      ex_rs = '0; ex_rt = '0; ex_rd = '0; ex_mem_read = 0; ex_reg_write = 0;
      mem_rd = '0; mem_reg_write = 0; mem_access = 0;
      wb_rd = '0; wb_reg_write = 0; dmem_ready = 1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1; idle();
      ex_rs = 5; mem_rd = 5; mem_reg_write = 1; mem_access = 1;
      @(negedge clk);
      n_cmp++;
      if ({pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush, fwd_a, fwd_b, dmem_req}
          !== 12'b0000_111_00_00_0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %b want %b",
                  {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush, fwd_a, fwd_b, dmem_req},
                  12'b0000_111_00_00_0);
      end
      next_cycle();
      reset = 0; idle();
      @(negedge clk);
      n_cmp++;
      if ({timeout_err, stall_cycles, flush_count, pc_en, ifid_en, idex_en, exmem_en,
           ifid_flush, idex_flush, memwb_flush, dmem_req} !== {1'b0, 4'd0, 4'd0, 4'b1111, 3'b000, 1'b0}) begin
         n_bad++;
         $display("FAIL after_reset: got terr=%0d stall=%0d flush=%0d en=%b fl=%b req=%0d want 0 0 0 1111 000 0",
                  timeout_err, stall_cycles, flush_count, {pc_en, ifid_en, idex_en, exmem_en},
                  {ifid_flush, idex_flush, memwb_flush}, dmem_req);
      end
      next_cycle();
   endtask

   task automatic test_load_use();
      idle();
      ex_mem_read = 1; ex_reg_write = 1; ex_rd = 2; id_rs = 2;
      @(negedge clk);
      n_cmp++;
      if ({pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush} !== 7'b0011_010) begin
         n_bad++;
         $display("FAIL load_use_stall: got %b want %b",
                  {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush}, 7'b0011_010);
      end
      next_cycle();
      idle();
      id_rs = 2;
      @(negedge clk);
      n_cmp++;
      if ({pc_en, ifid_en, idex_flush, stall_cycles} !== {3'b110, 4'd1}) begin
         n_bad++;
         $display("FAIL load_use_resume: got en/fl=%b stall=%0d want 110 1",
                  {pc_en, ifid_en, idex_flush}, stall_cycles);
      end
      next_cycle();
      // rt only counts when the ID instruction actually reads it
      idle();
      ex_mem_read = 1; ex_reg_write = 1; ex_rd = 7; id_rt = 7; id_uses_rt = 0;
      @(negedge clk);
      n_cmp++;
      if (pc_en !== 1'b1) begin
         n_bad++;
         $display("FAIL load_use_rt_unused: got pc_en=%0d want 1", pc_en);
      end
      ex_rd = 0; id_rs = 0; id_rt = 0; id_uses_rt = 1;
      #1;
      n_cmp++;
      if (pc_en !== 1'b1) begin
         n_bad++;
         $display("FAIL load_use_r0: got pc_en=%0d want 1", pc_en);
      end
      next_cycle();
   endtask

   task automatic test_fwd_priority();
      idle();
      ex_rs = 5; ex_rt = 9; mem_rd = 5; wb_rd = 5; mem_reg_write = 1; wb_reg_write = 1;
      @(negedge clk);
      n_cmp++;
      if ({fwd_a, fwd_b} !== 4'b10_00) begin
         n_bad++;
         $display("FAIL fwd_exmem_wins: got a=%b b=%b want a=10 b=00", fwd_a, fwd_b);
      end
      mem_rd = 0;
      #1;
      n_cmp++;
      if ({fwd_a, fwd_b} !== 4'b01_00) begin
         n_bad++;
         $display("FAIL fwd_memwb: got a=%b b=%b want a=01 b=00", fwd_a, fwd_b);
      end
      mem_rd = 9; wb_rd = 0; ex_rs = 0;
      #1;
      n_cmp++;
      if ({fwd_a, fwd_b} !== 4'b00_10) begin
         n_bad++;
         $display("FAIL fwd_b_exmem: got a=%b b=%b want a=00 b=10", fwd_a, fwd_b);
      end
      next_cycle();
   endtask

   task automatic test_branch_loaduse();
      idle();
      ex_mem_read = 1; ex_reg_write = 1; ex_rd = 3; id_rt = 3; id_uses_rt = 1; id_branch_taken = 1;
      @(negedge clk);
      n_cmp++;
      if ({pc_en, ifid_flush, idex_flush} !== 3'b001) begin
         n_bad++;
         $display("FAIL branch_blocked: got pc/ifid_fl/idex_fl=%b want 001", {pc_en, ifid_flush, idex_flush});
      end
      next_cycle();
      idle();
      id_rt = 3; id_uses_rt = 1; id_branch_taken = 1;
      @(negedge clk);
      n_cmp++;
      if ({pc_en, ifid_en, ifid_flush, idex_flush} !== 4'b1110) begin
         n_bad++;
         $display("FAIL branch_flush: got %b want 1110", {pc_en, ifid_en, ifid_flush, idex_flush});
      end
      next_cycle();
      idle();
      @(negedge clk);
      n_cmp++;
      if ({flush_count, stall_cycles} !== {4'd1, 4'd2}) begin
         n_bad++;
         $display("FAIL branch_counts: got flush=%0d stall=%0d want 1 2", flush_count, stall_cycles);
      end
      next_cycle();
   endtask

   task automatic test_mem_latency();
      for (int i = 1; i <= 3; i++) begin
         idle();
         mem_access = 1; dmem_ready = 0; id_branch_taken = 1;
         @(negedge clk);
         n_cmp++;
         if ({pc_en, ifid_en, idex_en, exmem_en, ifid_flush, memwb_flush, dmem_req} !== 7'b0000_011) begin
            n_bad++;
            $display("FAIL mem_wait_c%0d: got %b want 0000011", i,
                     {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, memwb_flush, dmem_req});
         end
         next_cycle();
      end
      idle();
      mem_access = 1; dmem_ready = 1;
      @(negedge clk);
      n_cmp++;
      if ({pc_en, ifid_en, idex_en, exmem_en, memwb_flush, dmem_req} !== 6'b1111_01) begin
         n_bad++;
         $display("FAIL mem_resume: got %b want 111101",
                  {pc_en, ifid_en, idex_en, exmem_en, memwb_flush, dmem_req});
      end
      next_cycle();
      idle();
      @(negedge clk);
      n_cmp++;
      if ({stall_cycles, flush_count, dmem_req} !== {4'd5, 4'd1, 1'b0}) begin
         n_bad++;
         $display("FAIL mem_counts: got stall=%0d flush=%0d req=%0d want 5 1 0",
                  stall_cycles, flush_count, dmem_req);
      end
      next_cycle();
   endtask

   task automatic test_timeout();
      for (int i = 1; i <= TIMEOUT; i++) begin
         idle();
         mem_access = 1; dmem_ready = 0;
         @(negedge clk);
         n_cmp++;
         if ({timeout_err, pc_en, exmem_en, dmem_req} !== 4'b0001) begin
            n_bad++;
            $display("FAIL timeout_wait_c%0d: got terr/pc/exmem/req=%b want 0001", i,
                     {timeout_err, pc_en, exmem_en, dmem_req});
         end
         next_cycle();
      end
      for (int i = 0; i < 3; i++) begin
         idle();
         mem_access = i[0]; dmem_ready = 1; id_branch_taken = 1;
         @(negedge clk);
         n_cmp++;
         if ({timeout_err, pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush,
              dmem_req, stall_cycles, flush_count} !== {1'b1, 4'b0000, 3'b111, 1'b0, 4'd15, 4'd1}) begin
            n_bad++;
            $display("FAIL trap_c%0d: got terr=%0d en=%b fl=%b req=%0d stall=%0d flush=%0d want 1 0000 111 0 15 1", i,
                     timeout_err, {pc_en, ifid_en, idex_en, exmem_en}, {ifid_flush, idex_flush, memwb_flush},
                     dmem_req, stall_cycles, flush_count);
         end
         next_cycle();
      end
      reset = 1; idle();
      next_cycle();
      reset = 0;
      @(negedge clk);
      n_cmp++;
      if ({timeout_err, stall_cycles, flush_count, pc_en, exmem_en} !== {1'b0, 4'd0, 4'd0, 2'b11}) begin
         n_bad++;
         $display("FAIL trap_reset: got terr=%0d stall=%0d flush=%0d pc=%0d exmem=%0d want 0 0 0 1 1",
                  timeout_err, stall_cycles, flush_count, pc_en, exmem_en);
      end
      next_cycle();
   endtask

   task automatic test_reset_mid_wait();
      idle();
      mem_access = 1; dmem_ready = 0;
      next_cycle();
      reset = 1;
      @(negedge clk);
      n_cmp++;
      if ({dmem_req, pc_en, ifid_flush} !== 3'b001) begin
         n_bad++;
         $display("FAIL reset_in_wait: got req/pc/ifid_fl=%b want 001", {dmem_req, pc_en, ifid_flush});
      end
      next_cycle();
      reset = 0; idle();
      @(negedge clk);
      n_cmp++;
      if ({dmem_req, pc_en, memwb_flush, stall_cycles} !== {3'b010, 4'd0}) begin
         n_bad++;
         $display("FAIL after_reset_wait: got req/pc/memwb_fl=%b stall=%0d want 010 0",
                  {dmem_req, pc_en, memwb_flush}, stall_cycles);
      end
      next_cycle();
   endtask

   function automatic logic [1:0] ref_fwd(int src, int mrd, int mw, int wrd, int ww);
      if (mw != 0 && mrd != 0 && mrd == src) return 2'b10;
      if (ww != 0 && wrd != 0 && wrd == src) return 2'b01;
      return 2'b00;
   endfunction

   task automatic test_random();
      int m_mode;    // 0 running, 1 waiting on memory, 2 trapped
      int m_waited;
      int m_stall, m_flush, m_terr;
      logic [20:0] exp_v, got_v;
      logic [3:0] e_en;
      logic [2:0] e_fl;
      logic e_req;
      bit lu, stall_now, flush_now;
      m_mode = 0; m_waited = 0; m_stall = 0; m_flush = 0; m_terr = 0;
      reset = 1; idle();
      next_cycle();
      reset = 0;
      for (int c = 0; c < 800; c++) begin
         reset           = ($urandom_range(0, 59) == 0);
         id_rs           = REG_AW'($urandom_range(0, 3));
         id_rt           = REG_AW'($urandom_range(0, 3));
         id_uses_rt      = $urandom_range(0, 1);
         id_branch_taken = ($urandom_range(0, 2) == 0);
         ex_rs           = REG_AW'($urandom_range(0, 3));
         ex_rt           = REG_AW'($urandom_range(0, 3));
         ex_rd           = REG_AW'($urandom_range(0, 3));
         ex_mem_read     = $urandom_range(0, 1);
         ex_reg_write    = $urandom_range(0, 1);
         mem_rd          = REG_AW'($urandom_range(0, 3));
         mem_reg_write   = $urandom_range(0, 1);
         mem_access      = ($urandom_range(0, 3) == 0) || (m_mode == 1 && $urandom_range(0, 1) == 0);
         wb_rd           = REG_AW'($urandom_range(0, 3));
         wb_reg_write    = $urandom_range(0, 1);
         dmem_ready      = (c % 200 > 150) ? 1'b0 : ($urandom_range(0, 3) != 0);

         lu = ex_mem_read && ex_reg_write && ex_rd != 0 &&
              (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
         e_en = 4'b1111; e_fl = 3'b000; e_req = mem_access;
         flush_now = 0;
         if (reset) begin
            e_en = 4'b0000; e_fl = 3'b111; e_req = 0;
         end else if (m_mode == 2) begin
            e_en = 4'b0000; e_fl = 3'b111; e_req = 0;
         end else if (m_mode == 1) begin
            e_req = 1;
            if (!dmem_ready) begin e_en = 4'b0000; e_fl = 3'b001; end
         end else if (mem_access && !dmem_ready) begin
            e_en = 4'b0000; e_fl = 3'b001; e_req = 1;
         end else if (lu) begin
            e_en = 4'b0011; e_fl = 3'b010;
         end else if (id_branch_taken) begin
            e_fl = 3'b100; flush_now = 1;
         end
         exp_v = {e_en, e_fl,
                  reset ? 2'b00 : ref_fwd(ex_rs, mem_rd, mem_reg_write, wb_rd, wb_reg_write),
                  reset ? 2'b00 : ref_fwd(ex_rt, mem_rd, mem_reg_write, wb_rd, wb_reg_write),
                  e_req, m_terr[0], 4'(m_stall), 4'(m_flush)};
         @(negedge clk);
         got_v = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush,
                  fwd_a, fwd_b, dmem_req, timeout_err, stall_cycles, flush_count};
         n_cmp++;
         if (got_v !== exp_v) begin
            n_bad++;
            $display("FAIL random_c%0d: got %b want %b (mode=%0d waited=%0d)", c, got_v, exp_v, m_mode, m_waited);
         end

         stall_now = !e_en[3] && m_mode != 2;
         if (reset) begin
            m_mode = 0; m_waited = 0; m_stall = 0; m_flush = 0; m_terr = 0;
         end else begin
            if (stall_now && m_stall < SAT) m_stall++;
            if (flush_now && m_flush < SAT) m_flush++;
            if (m_mode == 0 && mem_access && !dmem_ready) begin
               m_waited = 1;
               m_mode = (m_waited >= TIMEOUT) ? 2 : 1;
            end else if (m_mode == 1) begin
               if (dmem_ready) begin
                  m_mode = 0; m_waited = 0;
               end else begin
                  m_waited++;
                  if (m_waited == TIMEOUT) m_mode = 2;
               end
            end
            if (m_mode == 2) m_terr = 1;
         end
         next_cycle();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1;
      idle();
      test_reset();
      test_load_use();
      test_fwd_priority();
      test_branch_loaduse();
      test_mem_latency();
      test_timeout();
      test_reset_mid_wait();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
